// File: rtl/sugar_setup_ctrl_pkg.sv
// Shared constants, state encoding and LFSR step for the sugar setup sequencer.
// Grid limits here are defaults; the controller can override them per instance.
package sugar_setup_ctrl_pkg;

   localparam int X_bits            = 8;
   localparam int Y_bits            = 8;
   localparam int X_MAX             = 127;
   localparam int Y_MAX             = 95;
   localparam int SUGARPATCH_RADIUS = 1;

   localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;

   typedef enum logic [2:0] {
      IDLE,
      GEN,
      CHECK,
      COMMIT,
      SWEEP,
      DONE
   } setup_state_t;

   // Fibonacci form, taps 16,14,13,11, shifting towards the MSB.
   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
   endfunction

endpackage

// File: rtl/sugar_setup_ctrl_lfsr16.sv
// 16-bit candidate generator with seed load and enable.
// A zero seed would lock the register up, so it is replaced by the default.
module lfsr16
   import sugar_setup_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [15:0] seed,
   input  logic        en,
   output logic [15:0] value
);

   logic [15:0] value_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         value_reg <= LFSR_DEFAULT;
      end else if (load) begin
         value_reg <= (seed == 16'h0000) ? LFSR_DEFAULT : seed;
      end else if (en) begin
         value_reg <= lfsr_step(value_reg);
      end
   end

   assign value = value_reg;

endmodule

// File: rtl/sugar_setup_ctrl.sv
// Setup sequencer: places NUM_PATCHES sugar patches at random non-overlapping
// centres, then raster-sweeps the grid turning patch hits into map writes.
module sugar_setup_ctrl
   import sugar_setup_ctrl_pkg::*;
#(
   parameter int X_bits      = sugar_setup_ctrl_pkg::X_bits,
   parameter int Y_bits      = sugar_setup_ctrl_pkg::Y_bits,
   parameter int NUM_PATCHES = 4,
   parameter int X_MAX       = sugar_setup_ctrl_pkg::X_MAX,
   parameter int Y_MAX       = sugar_setup_ctrl_pkg::Y_MAX,
   parameter int MAX_TRIES   = 64
) (
   input  logic                   setup_clk,
   input  logic                   RESET,
   input  logic                   start,
   input  logic [15:0]            seed,
   input  logic [NUM_PATCHES-1:0] collision_vec,
   input  logic [NUM_PATCHES-1:0] place_vec,
   output logic                   SETUP_PHASE,
   output logic [NUM_PATCHES-1:0] SET,
   output logic [X_bits-1:0]      in_x,
   output logic [Y_bits-1:0]      in_y,
   output logic [X_bits-1:0]      collide_x,
   output logic [Y_bits-1:0]      collide_y,
   output logic [X_bits-1:0]      writeLoc_x,
   output logic [Y_bits-1:0]      writeLoc_y,
   output logic                   SETUP_SUGARPLACE,
   output logic                   sug_we,
   output logic [NUM_PATCHES-1:0] placed_mask,
   output logic                   skip_err,
   output logic                   done
);

   localparam int K_W = (NUM_PATCHES > 1) ? $clog2(NUM_PATCHES) : 1;
   localparam int T_W = $clog2(MAX_TRIES + 1);

   localparam logic [K_W-1:0]    K_LAST = K_W'(NUM_PATCHES - 1);
   localparam logic [T_W-1:0]    T_LAST = T_W'(MAX_TRIES - 1);
   localparam logic [X_bits-1:0] X_LIM  = X_bits'(X_MAX);
   localparam logic [Y_bits-1:0] Y_LIM  = Y_bits'(Y_MAX);

   setup_state_t             state_reg;
   logic [K_W-1:0]           k_reg;
   logic [T_W-1:0]           tries_reg;
   logic [NUM_PATCHES-1:0]   set_reg;
   logic [NUM_PATCHES-1:0]   placed_reg;
   logic [X_bits-1:0]        in_x_reg;
   logic [Y_bits-1:0]        in_y_reg;
   logic [X_bits-1:0]        wl_x_reg;
   logic [Y_bits-1:0]        wl_y_reg;
   logic                     setup_phase_reg;
   logic                     sugarplace_reg;
   logic                     skip_err_reg;
   logic                     done_reg;

   logic [15:0]              lfsr_value;
   logic [X_bits-1:0]        cand_x;
   logic [Y_bits-1:0]        cand_y;
   logic                     cand_oob;
   logic                     hit;
   logic                     reject;
   logic                     exhaust;
   logic                     last_patch;
   logic                     enter_sweep;
   logic                     start_ok;
   logic [NUM_PATCHES-1:0]   set_onehot;

   assign cand_x      = lfsr_value[X_bits-1:0];
   assign cand_y      = lfsr_value[8 +: Y_bits];
   assign cand_oob    = (cand_x > X_LIM) || (cand_y > Y_LIM);
   // The patch being placed has its mask bit clear, so it never blocks itself.
   assign hit         = |(collision_vec & placed_reg);
   assign reject      = ((state_reg == GEN) && cand_oob) || ((state_reg == CHECK) && hit);
   assign exhaust     = (tries_reg == T_LAST);
   assign last_patch  = (k_reg == K_LAST);
   assign enter_sweep = last_patch && ((state_reg == COMMIT) || (reject && exhaust));
   assign start_ok    = start && ((state_reg == IDLE) || (state_reg == DONE));

   generate
      for (genvar gi = 0; gi < NUM_PATCHES; gi++) begin : g_set_decode
         assign set_onehot[gi] = (k_reg == K_W'(gi));
      end
   endgenerate

   lfsr16 u_lfsr (
      .clk   (setup_clk),
      .rst_n (RESET),
      .load  (start_ok),
      .seed  (seed),
      .en    (state_reg == GEN),
      .value (lfsr_value)
   );

   always_ff @(posedge setup_clk) begin
      if (!RESET) begin
         state_reg       <= IDLE;
         k_reg           <= '0;
         tries_reg       <= '0;
         set_reg         <= '0;
         placed_reg      <= '0;
         in_x_reg        <= '0;
         in_y_reg        <= '0;
         wl_x_reg        <= '0;
         wl_y_reg        <= '0;
         setup_phase_reg <= 1'b0;
         sugarplace_reg  <= 1'b0;
         skip_err_reg    <= 1'b0;
         done_reg        <= 1'b0;
      end else begin
         set_reg <= '0;
         case (state_reg)
            IDLE, DONE: begin
               if (start) begin
                  state_reg       <= GEN;
                  k_reg           <= '0;
                  tries_reg       <= '0;
                  placed_reg      <= '0;
                  skip_err_reg    <= 1'b0;
                  done_reg        <= 1'b0;
                  setup_phase_reg <= 1'b1;
                  wl_x_reg        <= '0;
                  wl_y_reg        <= '0;
               end
            end
            GEN: begin
               in_x_reg <= cand_x;
               in_y_reg <= cand_y;
               if (!cand_oob) begin
                  state_reg <= CHECK;
               end
            end
            CHECK: begin
               if (!hit) begin
                  state_reg <= COMMIT;
                  set_reg   <= set_onehot;
               end
            end
            COMMIT: begin
               placed_reg <= placed_reg | set_reg;
               k_reg      <= k_reg + 1'b1;
               tries_reg  <= '0;
               state_reg  <= last_patch ? SWEEP : GEN;
            end
            SWEEP: begin
               if ((wl_x_reg == X_LIM) && (wl_y_reg == Y_LIM)) begin
                  state_reg       <= DONE;
                  setup_phase_reg <= 1'b0;
                  sugarplace_reg  <= 1'b0;
                  done_reg        <= 1'b1;
               end else if (wl_x_reg == X_LIM) begin
                  wl_x_reg <= '0;
                  wl_y_reg <= wl_y_reg + 1'b1;
               end else begin
                  wl_x_reg <= wl_x_reg + 1'b1;
               end
            end
            default: state_reg <= IDLE;
         endcase

         // Rejects from GEN (out of bounds) and CHECK (collision) share one try budget.
         if (reject) begin
            if (exhaust) begin
               skip_err_reg <= 1'b1;
               tries_reg    <= '0;
               k_reg        <= k_reg + 1'b1;
               state_reg    <= last_patch ? SWEEP : GEN;
            end else begin
               tries_reg <= tries_reg + 1'b1;
               state_reg <= GEN;
            end
         end

         if (enter_sweep) begin
            sugarplace_reg <= 1'b1;
         end
      end
   end

   assign SETUP_PHASE      = setup_phase_reg;
   assign SET              = set_reg;
   assign in_x             = in_x_reg;
   assign in_y             = in_y_reg;
   assign collide_x        = in_x_reg;
   assign collide_y        = in_y_reg;
   assign writeLoc_x       = wl_x_reg;
   assign writeLoc_y       = wl_y_reg;
   assign SETUP_SUGARPLACE = sugarplace_reg;
   assign sug_we           = sugarplace_reg & (|(place_vec & placed_reg));
   assign placed_mask      = placed_reg;
   assign skip_err         = skip_err_reg;
   assign done             = done_reg;

endmodule

// File: tb/tb_sugar_setup_ctrl.sv
// Bench for sugar_setup_ctrl on an 8x8 grid with two radius-1 patches modelled
// here; a transaction-level placement model fills the expected SET/sweep queues.
module tb_sugar_setup_ctrl;

   localparam int NP = 2;
   localparam int XM = 7;
   localparam int YM = 7;
   localparam int MT = 4;
   localparam int R  = 1;

   logic          clk = 1'b0;
   logic          RESET = 1'b0;
   logic          start = 1'b0;
   logic [15:0]   seed = 16'h0000;
   logic [NP-1:0] collision_vec;
   logic [NP-1:0] place_vec;
   logic          SETUP_PHASE;
   logic [NP-1:0] SET;
   logic [7:0]    in_x, in_y, collide_x, collide_y, writeLoc_x, writeLoc_y;
   logic          SETUP_SUGARPLACE, sug_we, skip_err, done;
   logic [NP-1:0] placed_mask;

   always #5 clk = ~clk;

   sugar_setup_ctrl #(
      .X_bits(8), .Y_bits(8), .NUM_PATCHES(NP), .X_MAX(XM), .Y_MAX(YM), .MAX_TRIES(MT)
   ) dut (
      .setup_clk        (clk),
      .RESET            (RESET),
      .start            (start),
      .seed             (seed),
      .collision_vec    (collision_vec),
      .place_vec        (place_vec),
      .SETUP_PHASE      (SETUP_PHASE),
      .SET              (SET),
      .in_x             (in_x),
      .in_y             (in_y),
      .collide_x        (collide_x),
      .collide_y        (collide_y),
      .writeLoc_x       (writeLoc_x),
      .writeLoc_y       (writeLoc_y),
      .SETUP_SUGARPLACE (SETUP_SUGARPLACE),
      .sug_we           (sug_we),
      .placed_mask      (placed_mask),
      .skip_err         (skip_err),
      .done             (done)
   );

   int total = 0;
   int bad   = 0;

   function automatic bit near(input int ax, input int ay, input int bx, input int by, input int d);
      return (ax - bx <= d) && (bx - ax <= d) && (ay - by <= d) && (by - ay <= d);
   endfunction

   function automatic logic [15:0] step(input logic [15:0] v);
      logic fb;
      fb = v[15] ^ v[13] ^ v[12] ^ v[10];
      return {v[14:0], fb};
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Patch instances: latch centre on SET, collide if footprints would overlap.
   logic [7:0]    pat_x [NP] = '{default: 8'd0};
   logic [7:0]    pat_y [NP] = '{default: 8'd0};
   logic [NP-1:0] coll_model;
   logic          force_coll = 1'b0;

   always @(posedge clk) begin
      for (int i = 0; i < NP; i++) begin
         if (SET[i]) begin
            pat_x[i] <= in_x;
            pat_y[i] <= in_y;
         end
      end
   end

   always_comb begin
      coll_model = '0;
      place_vec  = '0;
      for (int i = 0; i < NP; i++) begin
         coll_model[i] = near(int'(collide_x), int'(collide_y), int'(pat_x[i]), int'(pat_y[i]), 2 * R);
         place_vec[i]  = near(int'(writeLoc_x), int'(writeLoc_y), int'(pat_x[i]), int'(pat_y[i]), R);
      end
      collision_vec = force_coll ? 2'b01 : coll_model;
   end

   // Scoreboard
   logic [17:0]   set_q[$];
   logic [16:0]   sweep_q[$];
   logic [NP-1:0] exp_mask;
   logic          exp_skip;
   int            exp_we_cnt;
   int            sweep_cnt = 0;
   int            we_cnt = 0;
   logic          prev_sp = 1'b0;
   logic [15:0]   prev_xy = 16'h0000;
   logic          done_prev = 1'b0;
   logic          done_rise_ok = 1'b0;

   task automatic model_run(input logic [15:0] s, input bit frc);
      logic [15:0]   l;
      logic [NP-1:0] oh;
      int            k, tries, cx, cy;
      int            px [NP];
      int            py [NP];
      bit            ok, we;
      l = (s == 16'h0000) ? 16'hACE1 : s;
      k = 0; tries = 0; exp_mask = '0; exp_skip = 1'b0; exp_we_cnt = 0;
      set_q.delete();
      sweep_q.delete();
      while (k < NP) begin
         cx = int'(l[7:0]);
         cy = int'(l[15:8]);
         l  = step(l);
         ok = (cx <= XM) && (cy <= YM);
         for (int i = 0; i < NP; i++) begin
            if (ok && exp_mask[i] && (frc ? (i == 0) : near(cx, cy, px[i], py[i], 2 * R))) ok = 1'b0;
         end
         if (ok) begin
            oh = '0;
            oh[k] = 1'b1;
            set_q.push_back({oh, 8'(cx), 8'(cy)});
            px[k] = cx; py[k] = cy; exp_mask[k] = 1'b1;
            k++; tries = 0;
         end else begin
            tries++;
            if (tries == MT) begin
               exp_skip = 1'b1; k++; tries = 0;
            end
         end
      end
      for (int y = 0; y <= YM; y++) begin
         for (int x = 0; x <= XM; x++) begin
            we = 1'b0;
            for (int i = 0; i < NP; i++) begin
               if (exp_mask[i] && near(x, y, px[i], py[i], R)) we = 1'b1;
            end
            exp_we_cnt += int'(we);
            sweep_q.push_back({8'(x), 8'(y), we});
         end
      end
   endtask

   always @(negedge clk) begin : monitor
      logic [17:0] es;
      logic [16:0] ew;
      if (SET != '0) begin
         check("set_expected", 64'(set_q.size() != 0), 64'd1);
         if (set_q.size() != 0) begin
            es = set_q.pop_front();
            check("set_txn", 64'({SET, in_x, in_y}), 64'(es));
         end
         $display("set txn: SET=%b centre=(%0d,%0d)", SET, in_x, in_y);
      end
      if (SETUP_SUGARPLACE) begin
         sweep_cnt++;
         we_cnt += int'(sug_we);
         check("sweep_expected", 64'(sweep_q.size() != 0), 64'd1);
         if (sweep_q.size() != 0) begin
            ew = sweep_q.pop_front();
            check("sweep_cell", 64'({writeLoc_x, writeLoc_y, sug_we}), 64'(ew));
         end
      end
      if (done && !done_prev) done_rise_ok = prev_sp && (prev_xy == {8'(XM), 8'(YM)});
      prev_sp   = SETUP_SUGARPLACE;
      prev_xy   = {writeLoc_x, writeLoc_y};
      done_prev = done;
   end

   task automatic do_run(input logic [15:0] s, input bit frc, input bit oob_probe);
      int          n;
      logic [15:0] l2;
      model_run(s, frc);
      force_coll   = frc;
      sweep_cnt    = 0;
      we_cnt       = 0;
      done_rise_ok = 1'b0;
      @(negedge clk);
      seed  = s;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (oob_probe) begin
         l2 = s;
         @(negedge clk);
         check("oob_first_x", 64'(in_x), 64'(l2[7:0]));
         check("phase_high", 64'(SETUP_PHASE), 64'd1);
         l2 = step(l2);
         @(negedge clk);
         check("oob_next_x", 64'(in_x), 64'(l2[7:0]));
         check("oob_next_y", 64'(in_y), 64'(l2[15:8]));
      end
      n = 0;
      while (!done && n < 20000) begin
         @(negedge clk);
         n++;
      end
      #1;
      check("run_timeout", 64'(n < 20000), 64'd1);
      check("set_q_drained", 64'(set_q.size()), 64'd0);
      check("sweep_q_drained", 64'(sweep_q.size()), 64'd0);
      check("sweep_len", 64'(sweep_cnt), 64'((XM + 1) * (YM + 1)));
      check("we_count", 64'(we_cnt), 64'(exp_we_cnt));
      check("placed_mask", 64'(placed_mask), 64'(exp_mask));
      check("skip_err", 64'(skip_err), 64'(exp_skip));
      check("done_after_last_cell", 64'(done_rise_ok), 64'd1);
      check("end_flags", 64'({SETUP_PHASE, SETUP_SUGARPLACE, sug_we}), 64'd0);
      $display("run seed=%h force=%0d: placed=%b skip_err=%0d sweep=%0d writes=%0d",
               s, frc, placed_mask, skip_err, sweep_cnt, we_cnt);
   endtask

   initial begin : stim
      int n;
      // Reset held with start asserted
      RESET = 1'b0;
      start = 1'b1;
      seed  = 16'h5555;
      repeat (2) begin
         @(negedge clk);
         check("reset_outputs",
               64'({SETUP_PHASE, SET, in_x, in_y, collide_x, collide_y, writeLoc_x, writeLoc_y,
                    SETUP_SUGARPLACE, sug_we, placed_mask, skip_err, done}), 64'd0);
      end
      RESET = 1'b1;
      start = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("idle_after_reset", 64'({done, SETUP_PHASE, SET}), 64'd0);
      end

      // First candidate x=0x34 is off the grid: GEN must retry without CHECK
      do_run(16'h1234, 1'b0, 1'b1);
      // Both patches placed, second one after one collision
      do_run(16'h0001, 1'b0, 1'b0);

      // Abort mid-sweep at (5,2)
      model_run(16'h0001, 1'b0);
      force_coll = 1'b0;
      @(negedge clk);
      seed  = 16'h0001;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!(SETUP_SUGARPLACE && writeLoc_x == 8'd5 && writeLoc_y == 8'd2) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("mid_sweep_reached", 64'(n < 2000), 64'd1);
      RESET = 1'b0;
      @(negedge clk);
      check("mid_reset_outputs",
            64'({SETUP_SUGARPLACE, SETUP_PHASE, SET, placed_mask, writeLoc_x, writeLoc_y, done, skip_err}),
            64'd0);
      RESET = 1'b1;
      set_q.delete();
      sweep_q.delete();
      $display("mid-sweep reset applied at (5,2)");
      // Same seed must replay the identical run
      do_run(16'h0001, 1'b0, 1'b0);

      // Patch 0 at (3,3); patch 1 blocked until its tries run out
      do_run(16'h0303, 1'b1, 1'b0);
      // Zero seed falls back to the default LFSR value
      do_run(16'h0000, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
